// File: rtl/add8_pkg.sv
// Shared constants and helpers for the byte-serial adder sequencer.
//   BYTE_W        width of one adder limb
//   ST_*          FSM state encodings
//   clog2()       ceiling log2, usable in parameter expressions
package add8_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/add8_seq_ctrl_if.sv
// Bundle between the requester, the sequencer and the shared 8-bit adder.
//   requester side : start, a, b, cin, (sub), busy, done, sum, cout
//   adder side     : add_a, add_b, add_cin (to adder), add_s, add_cout (from adder)
// master = environment (requester + adder), slave = sequencer.
// Optional: ADD8_SEQ_SUB_EN adds the sub request bit.
interface add8_seq_ctrl_if #(parameter int NBYTES = 4);
  import add8_pkg::*;

  logic                       start;
  logic [BYTE_W*NBYTES-1:0]   a;
  logic [BYTE_W*NBYTES-1:0]   b;
  logic                       cin;
`ifdef ADD8_SEQ_SUB_EN
  logic                       sub;
`endif
  logic                       busy;
  logic                       done;
  logic [BYTE_W*NBYTES-1:0]   sum;
  logic                       cout;
  logic [BYTE_W-1:0]          add_a;
  logic [BYTE_W-1:0]          add_b;
  logic                       add_cin;
  logic [BYTE_W-1:0]          add_s;
  logic                       add_cout;

  modport master (
`ifdef ADD8_SEQ_SUB_EN
    output sub,
`endif
    output start, a, b, cin, add_s, add_cout,
    input  busy, done, sum, cout, add_a, add_b, add_cin
  );

  modport slave (
`ifdef ADD8_SEQ_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin, add_s, add_cout,
    output busy, done, sum, cout, add_a, add_b, add_cin
  );

endinterface

// File: rtl/add8_lat_cnt.sv
// Per-byte latency counter: counts 0..ADD_LAT while enabled and pulses hit
// on the cycle the count equals ADD_LAT (the adder result is valid then).
//   clk, rst_n  clock, async active-low reset
//   clr         force count to 0 (new operation accepted)
//   en          count this cycle (sequencer in RUN)
//   hit         count==ADD_LAT while enabled; counter wraps to 0
module add8_lat_cnt
  import add8_pkg::*;
#(
  parameter int ADD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int LATW = (clog2(ADD_LAT + 1) < 1) ? 1 : clog2(ADD_LAT + 1);

  logic [LATW-1:0] cnt;

  assign hit = en && (cnt == LATW'(ADD_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr || hit) cnt <= '0;
    else if (en)        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/add8_seq_ctrl.sv
// Byte-serial multi-precision adder sequencer. Feeds one limb per slot to an
// external registered 8-bit adder, chains carry between limbs and assembles
// {cout,sum} = a + b + cin over NBYTES limbs.
//   clk, rst_n  clock, async active-low reset
//   bus         add8_seq_ctrl_if.slave: requester handshake + adder operands
// Parameters: NBYTES limbs, ADD_LAT adder latency in edges.
// Optional: define ADD8_SEQ_SUB_EN for a-b via latched ~b and forced carry-in.
module add8_seq_ctrl
  import add8_pkg::*;
#(
  parameter int NBYTES  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  add8_seq_ctrl_if.slave bus
);

  localparam int IDXW = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES);

  logic [1:0]                     state, nxt;
  logic [NBYTES-1:0][BYTE_W-1:0]  opa, opb, sum_q;
  logic [IDXW-1:0]                idx;
  logic                           carry, cout_q;
  logic                           hit, accept, last;

  assign accept = (state == ST_IDLE) && bus.start;
  assign last   = (idx == IDXW'(NBYTES - 1));

  add8_lat_cnt #(.ADD_LAT(ADD_LAT)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == ST_RUN),
    .hit   (hit)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // next state; start is only looked at in IDLE
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start)   nxt = ST_RUN;
      ST_RUN:  if (hit && last) nxt = ST_DONE;
      ST_DONE:                  nxt = ST_IDLE;
      default:                  nxt = ST_IDLE;
    endcase
  end

  // outputs; adder operands are held for the whole slot since idx/carry only
  // move on the capture edge
  always_comb begin
    bus.busy    = (state == ST_RUN);
    bus.done    = (state == ST_DONE);
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state == ST_RUN) begin
      bus.add_a   = opa[idx];
      bus.add_b   = opb[idx];
      bus.add_cin = carry;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // operand latch, limb capture and carry chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      opa <= bus.a;
      idx <= '0;
`ifdef ADD8_SEQ_SUB_EN
      // a - b = a + ~b + 1; cout=1 means no borrow
      opb   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1   : bus.cin;
`else
      opb   <= bus.b;
      carry <= bus.cin;
`endif
    end else if ((state == ST_RUN) && hit) begin
      sum_q[idx] <= bus.add_s;
      carry      <= bus.add_cout;
      if (last) begin
        cout_q <= bus.add_cout;
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Self-checking bench: two sequencers (ADD_LAT=1 and ADD_LAT=3), each with a
// behavioural registered adder, driven from a vector table plus hand-written
// sequences for start-while-busy and mid-run reset.
module tb_add8_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          sel = 0;      // 0 -> dut1 (ADD_LAT=1), 1 -> dut3 (ADD_LAT=3)
  logic        st = 1'b0;
  logic [31:0] a_v = '0, b_v = '0;
  logic        cin_v = 1'b0;
`ifdef ADD8_SEQ_SUB_EN
  logic        sub_v = 1'b0;
`endif

  add8_seq_ctrl_if #(.NBYTES(4)) if1 ();
  add8_seq_ctrl_if #(.NBYTES(4)) if3 ();

  assign if1.start = st & (sel == 0);
  assign if3.start = st & (sel == 1);
  assign if1.a = a_v;  assign if3.a = a_v;
  assign if1.b = b_v;  assign if3.b = b_v;
  assign if1.cin = cin_v; assign if3.cin = cin_v;
`ifdef ADD8_SEQ_SUB_EN
  assign if1.sub = sub_v; assign if3.sub = sub_v;
`endif

  add8_seq_ctrl #(.NBYTES(4), .ADD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  add8_seq_ctrl #(.NBYTES(4), .ADD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // external registered adders
  logic [8:0] r1;
  logic [8:0] r3 [3];
  always_ff @(posedge clk) begin
    r1    <= 9'(if1.add_a) + 9'(if1.add_b) + 9'(if1.add_cin);
    r3[0] <= 9'(if3.add_a) + 9'(if3.add_b) + 9'(if3.add_cin);
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign if1.add_s = r1[7:0];    assign if1.add_cout = r1[8];
  assign if3.add_s = r3[2][7:0]; assign if3.add_cout = r3[2][8];

  logic        m_busy, m_done, m_cout, m_add_cin;
  logic [31:0] m_sum;
  logic [7:0]  m_add_a, m_add_b;
  always_comb begin
    if (sel == 0) begin
      m_busy = if1.busy; m_done = if1.done; m_cout = if1.cout; m_sum = if1.sum;
      m_add_a = if1.add_a; m_add_b = if1.add_b; m_add_cin = if1.add_cin;
    end else begin
      m_busy = if3.busy; m_done = if3.done; m_cout = if3.cout; m_sum = if3.sum;
      m_add_a = if3.add_a; m_add_b = if3.add_b; m_add_cin = if3.add_cin;
    end
  end

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic [3:0]  rip;   // expected add_cin per byte slot, bit j = slot j
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One operation: start pulse, then 40 cycles of observation. inj_k>=0 pulses
  // a second start at that cycle; rst_k>=0 asserts reset at that cycle.
  task automatic run_op(input vec_t v, input int inj_k, input int rst_k, input string nm);
    int sw, lat, busy_n, done_k, done_n, unst;
    logic [3:0]  rip;
    logic [31:0] eb;
    sel = v.sel;
    sw  = (v.sel == 0) ? 2 : 4;
    lat = 4 * sw;
    eb  = v.b;
`ifdef ADD8_SEQ_SUB_EN
    if (sub_v) eb = ~v.b;
`endif
    a_v = v.a; b_v = v.b; cin_v = v.cin; st = 1'b1;
    @(posedge clk); #1; st = 1'b0;
    busy_n = 0; done_k = -1; done_n = 0; unst = 0; rip = '0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; st = 1'b0; end
      if (m_done) begin done_n++; if (done_k < 0) done_k = k; end
      if (done_k < 0) busy_n += int'(m_busy);
      if (rst_k < 0 && k < lat) begin
        if (k % sw == 0) rip[k/sw] = m_add_cin;
        if (m_add_a !== v.a[(k/sw)*8 +: 8] || m_add_b !== eb[(k/sw)*8 +: 8] ||
            m_add_cin !== rip[k/sw]) unst++;
      end
      if (k == inj_k) begin
        a_v = 32'h12345678; b_v = 32'h11111111; cin_v = 1'b1; st = 1'b1;
      end
      if (k == rst_k) begin
        rst_n = 1'b0; #1;
        chk({nm, ".rst_busy"}, 64'(m_busy), 64'(0));
        chk({nm, ".rst_sum"},  64'(m_sum),  64'(0));
        chk({nm, ".rst_cout"}, 64'(m_cout), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    if (rst_k < 0) begin
      chk({nm, ".done_lat"}, 64'(done_k), 64'(lat));
      chk({nm, ".busy_cyc"}, 64'(busy_n), 64'(lat));
      chk({nm, ".done_cnt"}, 64'(done_n), 64'(1));
      chk({nm, ".sum"},      64'(m_sum),  64'(v.s));
      chk({nm, ".cout"},     64'(m_cout), 64'(v.co));
      chk({nm, ".ripple"},   64'(rip),    64'(v.rip));
      chk({nm, ".stable"},   64'(unst),   64'(0));
    end else begin
      chk({nm, ".no_done"},  64'(done_n), 64'(0));
    end
  endtask

  initial begin
    tv[0] = '{0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 4'b0010};
    tv[1] = '{0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4'b1111};
    tv[2] = '{0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 4'b0000};
    tv[3] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 4'b0000};
    tv[4] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b1111};
    tv[5] = '{0, 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 4'b1010};
    tv[6] = '{1, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 4'b1111};
    tv[7] = '{1, 32'h04030201, 32'h10203040, 1'b0, 32'h14233241, 1'b0, 4'b0000};

    #3;
    chk("reset.busy",    64'(if1.busy),    64'(0));
    chk("reset.done",    64'(if1.done),    64'(0));
    chk("reset.sum",     64'(if1.sum),     64'(0));
    chk("reset.cout",    64'(if1.cout),    64'(0));
    chk("reset.add_a",   64'(if1.add_a),   64'(0));
    chk("reset.add_b",   64'(if1.add_b),   64'(0));
    chk("reset.add_cin", 64'(if1.add_cin), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_op(tv[i], -1, -1, $sformatf("v%0d", i));

    run_op(tv[0], 3, -1, "busy_start");
    run_op(tv[0], -1, 4, "mid_reset");
    run_op(tv[2], -1, -1, "after_reset");

`ifdef ADD8_SEQ_SUB_EN
    begin
      vec_t sv;
      sub_v = 1'b1;
      sv = '{0, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 4'b0001};
      run_op(sv, -1, -1, "sub_5m7");
      sv = '{0, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1, 4'b1111};
      run_op(sv, -1, -1, "sub_7m5");
      sub_v = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add8_seq_ctrl.md
Name: add8_seq_ctrl

Overview:
- Sequencer that drives the team's 8-bit synchronous (registered) ripple adder byte-serially to perform NBYTES-wide multi-precision addition.
- Carry-out of each byte is chained into the carry-in of the next byte.
- Sits between a requester (start/done handshake, wide operands) and one shared 8-bit adder instance. The adder is external; this block owns its operand/carry inputs.

Parameters:
- NBYTES, 4, number of 8-bit limbs per operation (>=1).
- ADD_LAT, 1, clock edges from stable adder inputs to valid add_s/add_cout (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse/level; sampled only in IDLE.
- a  in  8*NBYTES  operand A; latched on start accept.
- b  in  8*NBYTES  operand B; latched on start accept.
- cin  in  1  initial carry-in; latched on start accept.
- busy  out  1  high while RUN.
- done  out  1  one-cycle completion pulse.
- sum  out  8*NBYTES  result; held until next start accept.
- cout  out  1  final carry-out; held with sum.
- add_a  out  8  adder operand A byte.
- add_b  out  8  adder operand B byte.
- add_cin  out  1  adder carry-in.
- add_s  in  8  adder registered sum.
- add_cout  in  1  adder registered carry-out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0, add_cin=0; byte index, latency counter and carry register cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: start=1 at a rising edge latches a, b, cin into operand registers, sets idx=0, carry=cin, lat=0 -> RUN.
- RUN: add_a=opA[idx*8+:8], add_b=opB[idx*8+:8], add_cin=carry, all held stable for the whole byte slot.
  - lat counts edges 0..ADD_LAT; on the edge where lat==ADD_LAT: sum[idx*8+:8]<=add_s, carry<=add_cout, lat<=0, idx<=idx+1.
  - Each byte takes ADD_LAT+1 cycles.
  - After the last byte's capture: cout<=add_cout -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start is ignored in DONE.
- Timing: start sampled at edge E0; done is high in the cycle after edge E0+NBYTES*(ADD_LAT+1). Default is 8 cycles.
- start while busy or done: ignored, no queueing; operand registers are not disturbed.
- Inputs a/b/cin changing during RUN have no effect.
- sum bytes update progressively during RUN; sum is valid only when done=1 and afterwards, until the next accept.
- rst_n low mid-RUN: immediate abort to reset values; no done pulse.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(8*NBYTES+1).
- idx width is clog2(NBYTES) with a minimum of 1; lat width is clog2(ADD_LAT+1).

Optional Feature:
- Macro: ADD8_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), latched on start accept. When sub=1:
  - opB is latched as ~b.
  - carry is initialised to 1 and cin is ignored.
  - Result is sum=a-b mod 2^(8*NBYTES); cout=1 means no borrow.
- Undefined: no sub port; always addition.

Decomposition:
- Shared package add8_pkg holds:
  - BYTE_W=8;
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - function clog2.
- One natural sub-module: add8_lat_cnt, the per-byte latency counter. It takes clear/enable and emits a hit pulse when count==ADD_LAT.
- Byte muxing and capture stay in the top.

Test Plan:
- NBYTES=4, ADD_LAT=1: a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; check the carry ripples through all 4 byte slots via add_cin.
- Pulse start again 3 cycles into an op with a=0x12345678, b=0x11111111 -> ignored; first op result unchanged; no second done.
- Assert rst_n=0 during byte 2 -> busy=0, sum=0, cout=0 immediately; no done pulse; a new start after release produces the correct result.
- ADD_LAT=3: a=0xAAAAAAAA, b=0x55555555, cin=1 -> sum=0x00000000, cout=1; done 16 cycles after the start edge; add_a/add_b stable for 4 cycles per byte.
- With ADD8_SEQ_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
